// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, with a registered result.
// Latency: a request accepted in cycle N gets its response valid in cycle N+2. One operation is in flight at a time.
// Backpressure: the owner holds RESP until its rsp_ready, and no request is accepted outside IDLE.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;          // preferred requester when both are valid
  logic        owner_q, owner_d;      // requester whose operation is in flight
  logic [31:0] data1_q, data1_d;
  logic [31:0] data2_q, data2_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [15:0] op_count_q, op_count_d;

  logic grant0, grant1;
  logic rsp_hs;

  // Grant selection, next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    op_d         = op_q;
    rsp_result_d = rsp_result_q;
    op_count_d   = op_count_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    rsp_hs       = 1'b0;

    case (state_q)
      IDLE: begin
        // A lone valid wins outright; on a tie the pointer decides.
        grant0 = req0_valid & (~req1_valid | ~ptr_q);
        grant1 = req1_valid & (~req0_valid |  ptr_q);
        if (grant0) begin
          data1_d = req0_data1;
          data2_d = req0_data2;
          op_d    = req0_op;
          owner_d = 1'b0;
          state_d = EXEC;
        end else if (grant1) begin
          data1_d = req1_data1;
          data2_d = req1_data2;
          op_d    = req1_op;
          owner_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        state_d      = RESP;
      end
      RESP: begin
        // Only the owner's ready completes the response.
        rsp_hs = owner_q ? rsp1_ready : rsp0_ready;
        if (rsp_hs) begin
          ptr_d      = ~owner_q;
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      data1_q      <= 32'd0;
      data2_q      <= 32'd0;
      op_q         <= 4'd0;
      rsp_result_q <= 32'd0;
      op_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      op_q         <= op_d;
      rsp_result_q <= rsp_result_d;
      op_count_q   <= op_count_d;
    end
  end

  // Output decode: the ALU sees operands only while executing
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp0_valid = (state_q == RESP) & ~owner_q;
    rsp1_valid = (state_q == RESP) &  owner_q;
    alu_data1  = 32'd0;
    alu_data2  = 32'd0;
    alu_op     = 4'd0;
    if (state_q == EXEC) begin
      alu_data1 = data1_q;
      alu_data2 = data2_q;
      alu_op    = op_q;
    end
    busy       = (state_q != IDLE);
    rsp_result = rsp_result_q;
    op_count   = op_count_q;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; clock and reset are listed first below.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester k presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  arbiter accepts requester k's operation this cycle.
REQ-006 req0_data1, req0_data2, req1_data1, req1_data2  input  32 each  operands per requester.
REQ-007 req0_op / req1_op  input  4 each  ALU opcode per requester, passed through unmodified.
REQ-008 rsp0_valid / rsp1_valid  output  1 each  result for requester k available.
REQ-009 rsp0_ready / rsp1_ready  input  1 each  requester k consumes result.
REQ-010 rsp_result  output  32  registered ALU result, shared by both response ports.
REQ-011 alu_data1, alu_data2  output  32 each  operands to the shared combinational ALU.
REQ-012 alu_op  output  4  opcode to the shared ALU.
REQ-013 alu_result  input  32  combinational result from the shared ALU.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 op_count  output  16  number of completed operations (response handshakes).

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE: if exactly one reqk_valid is high, reqk_ready SHALL be asserted combinationally for that k only.
REQ-018 IDLE, both valid: grant SHALL go to the requester indicated by a 1-bit priority pointer (0 after reset); the other ready stays low.
REQ-019 reqk_ready SHALL never be asserted outside IDLE, and never for both requesters in the same cycle.
REQ-020 On handshake (valid & ready) the block SHALL latch data1, data2, op and owner id, and move to EXEC on the next edge.
REQ-021 EXEC: alu_data1/alu_data2/alu_op SHALL drive the latched values; at the end of the cycle alu_result SHALL be captured into rsp_result; next state RESP.
REQ-022 In IDLE and RESP, alu_data1, alu_data2, alu_op SHALL be driven to zero.
REQ-023 RESP: rspk_valid SHALL be high for the owner only, rsp_result held stable until rspk_ready is sampled high.
REQ-024 On response handshake: next state IDLE, priority pointer set to the non-owner, op_count incremented by 1.
REQ-025 op_count SHALL wrap from 16'hFFFF to 16'h0000 without flag.
REQ-026 Latency: handshake at edge N → rsp_valid high from edge N+2; minimum issue interval 3 cycles when rsp_ready is held high.
REQ-027 A requester dropping valid before its ready SHALL simply not be granted; no state change.
REQ-028 Non-owner rsp_ready SHALL be ignored; rsp_result SHALL retain its last value in IDLE.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force: state IDLE, pointer 0, op_count 0, rsp_result 0, latched operands/op/owner 0, all rsp valid 0, busy 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the operation with no response and no op_count increment.
REQ-031 After rst_n deasserts, the first grant SHALL be evaluated in the first IDLE cycle.

Verification
REQ-032 Single request: req0 data1=4, data2=3, op=4'b0010 (bench ALU model: add), rsp0_ready=1 → rsp0_valid 2 cycles after accept, rsp_result=7, op_count=1.
REQ-033 Simultaneous: both valid after reset → req0 granted first, then req1; with both held valid, grants alternate 0,1,0,1 over four operations.
REQ-034 Backpressure: rsp1_ready low for 5 cycles → rsp1_valid and rsp_result stable, busy=1, req0_ready stays 0 throughout.
REQ-035 Reset mid-operation: rst_n pulsed low in EXEC → all outputs at reset values in same cycle, no rsp_valid afterward, op_count=0.
REQ-036 Wrap: preload via 65536 completed operations → op_count reads 0, no other effect.
REQ-037 Assertions: reqk_ready and rspk_valid never both high; req0_ready & req1_ready never high; alu_op=0 outside EXEC.
